axis_sequence_checker: RTL and testbench

// AXI-Stream sink for the receiving end of the counting test-stream master. Accepts beats, checks

---
 rtl/axis_sequence_checker.sv | 213 +++++++++++++++++++++
 tb/tb_axis_sequence_checker.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sequence_checker.sv
// axis_sequence_checker
//
// AXI-Stream sink that checks a counting test stream. Every packet is expected
// to carry VALUE_COUNT beats with tdata START_VALUE, START_VALUE+1, ... and
// tlast on the final beat. Mismatches are counted and latched in sticky flags.
// After a data mismatch the expected value resynchronises to the received value
// plus one, so a single discontinuity costs exactly one error.
//
// Optional feature: define BACKPRESSURE_EN to gate tready with bit 0 of a
// free-running 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1), which
// forces the upstream master through pseudo-random stalls.
//
// Ports
//   aclk            clock, rising edge
//   rst             asynchronous reset, active-high
//   s_axis_tdata    stream data
//   s_axis_tvalid   stream valid
//   s_axis_tready   stream ready (depends only on state, enable, clear, LFSR)
//   s_axis_tlast    end of packet marker
//   enable          level; high allows beats to be accepted
//   clear           synchronous pulse; restart the checker and zero all status
//   done            high once MAX_PACKETS packets have completed (until clear)
//   pkt_count       packets completed (accepted beats carrying tlast)
//   beat_count      beats accepted
//   err_count       beats with at least one error
//   err_data        sticky: a tdata mismatch was seen
//   err_last        sticky: tlast was early, late or missing
//   last_data       tdata of the most recently accepted beat
module axis_sequence_checker #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int VALUE_COUNT      = 8,
    parameter int START_VALUE      = 10,
    parameter int MAX_PACKETS      = 1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic                        enable,
    input  logic                        clear,
    output logic                        done,
    output logic [CNT_WIDTH-1:0]        pkt_count,
    output logic [CNT_WIDTH-1:0]        beat_count,
    output logic [CNT_WIDTH-1:0]        err_count,
    output logic                        err_data,
    output logic                        err_last,
    output logic [AXIS_TDATA_WIDTH-1:0] last_data
);

    localparam int                          IDX_W    = (VALUE_COUNT > 1) ? $clog2(VALUE_COUNT) : 1;
    localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(VALUE_COUNT - 1);
    localparam logic [AXIS_TDATA_WIDTH-1:0] START_V  = AXIS_TDATA_WIDTH'(START_VALUE);
    localparam logic [CNT_WIDTH-1:0]        CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]        MAX_PKT  = CNT_WIDTH'(MAX_PACKETS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [AXIS_TDATA_WIDTH-1:0]   exp_q, exp_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CNT_WIDTH-1:0]          pkt_q, pkt_d;
    logic [CNT_WIDTH-1:0]          beat_q, beat_d;
    logic [CNT_WIDTH-1:0]          err_q, err_d;
    logic                          err_data_q, err_data_d;
    logic                          err_last_q, err_last_d;
    logic [AXIS_TDATA_WIDTH-1:0]   last_q, last_d;

    logic                          bp_ok;
    logic                          accept;
    logic                          data_bad;
    logic                          at_end;
    logic                          last_bad;
    logic [CNT_WIDTH-1:0]          pkt_inc;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

`ifdef BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Runs every cycle regardless of state so the stall pattern is independent
    // of traffic; clear does not reseed it.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign bp_ok = lfsr_q[0];
`else
    assign bp_ok = 1'b1;
`endif

    // tready must never look at tvalid; clear blocks acceptance in its cycle.
    assign s_axis_tready = (state_q == S_RUN) && enable && !clear && bp_ok;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign data_bad = (s_axis_tdata != exp_q);
    assign at_end   = (idx_q == LAST_IDX);
    assign last_bad = (s_axis_tlast != at_end);
    assign pkt_inc  = sat_inc(pkt_q);

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        idx_d      = idx_q;
        pkt_d      = pkt_q;
        beat_d     = beat_q;
        err_d      = err_q;
        err_data_d = err_data_q;
        err_last_d = err_last_q;
        last_d     = last_q;

        if (clear) begin
            state_d    = S_IDLE;
            exp_d      = START_V;
            idx_d      = '0;
            pkt_d      = '0;
            beat_d     = '0;
            err_d      = '0;
            err_data_d = 1'b0;
            err_last_d = 1'b0;
            last_d     = '0;
        end else begin
            if (accept) begin
                beat_d     = sat_inc(beat_q);
                last_d     = s_axis_tdata;
                err_data_d = err_data_q | data_bad;
                err_last_d = err_last_q | last_bad;
                if (data_bad || last_bad) begin
                    err_d = sat_inc(err_q);
                end
                // Either tlast or the final slot closes the packet; a missing
                // tlast restarts the count without crediting a packet.
                if (s_axis_tlast || at_end) begin
                    idx_d = '0;
                    exp_d = START_V;
                end else begin
                    idx_d = idx_q + 1'b1;
                    exp_d = data_bad ? s_axis_tdata + 1'b1 : exp_q + 1'b1;
                end
                if (s_axis_tlast) begin
                    pkt_d = pkt_inc;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (accept && s_axis_tlast && (MAX_PACKETS != 0) && (pkt_inc == MAX_PKT)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            exp_q      <= START_V;
            idx_q      <= '0;
            pkt_q      <= '0;
            beat_q     <= '0;
            err_q      <= '0;
            err_data_q <= 1'b0;
            err_last_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            idx_q      <= idx_d;
            pkt_q      <= pkt_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            err_data_q <= err_data_d;
            err_last_q <= err_last_d;
            last_q     <= last_d;
        end
    end

    assign done       = (state_q == S_DONE);
    assign pkt_count  = pkt_q;
    assign beat_count = beat_q;
    assign err_count  = err_q;
    assign err_data   = err_data_q;
    assign err_last   = err_last_q;
    assign last_data  = last_q;

endmodule

// File: tb/tb_axis_sequence_checker.sv
// Bench for axis_sequence_checker. Two instances share the clock and reset:
// dut0 stops after one packet (16-bit counters), dut1 runs unlimited with
// 12-bit counters so a long random run drives beat_count into saturation.
module tb_axis_sequence_checker;

    localparam int          VC    = 8;
    localparam logic [31:0] SV    = 32'd10;
    localparam int          MAXP0 = 1;
    localparam int          MAXP1 = 0;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b1;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic [31:0] tdata [2];
    logic        tvalid[2];
    logic        tlast [2];
    logic        en    [2];
    logic        clr   [2];

    logic        rdy0, rdy1, done0, done1, ed0, ed1, el0, el1;
    logic [15:0] pkt0, beat0, err0;
    logic [11:0] pkt1, beat1, err1;
    logic [31:0] ld0, ld1;

    logic        tready[2];
    logic        done  [2];
    logic        ed    [2];
    logic        el    [2];
    logic [15:0] pkt   [2];
    logic [15:0] beat  [2];
    logic [15:0] errc  [2];
    logic [31:0] lastd [2];

    assign tready[0] = rdy0;  assign tready[1] = rdy1;
    assign done[0]   = done0; assign done[1]   = done1;
    assign ed[0]     = ed0;   assign ed[1]     = ed1;
    assign el[0]     = el0;   assign el[1]     = el1;
    assign pkt[0]    = pkt0;  assign pkt[1]    = {4'b0, pkt1};
    assign beat[0]   = beat0; assign beat[1]   = {4'b0, beat1};
    assign errc[0]   = err0;  assign errc[1]   = {4'b0, err1};
    assign lastd[0]  = ld0;   assign lastd[1]  = ld1;

    axis_sequence_checker #(
        .AXIS_TDATA_WIDTH(32), .VALUE_COUNT(VC), .START_VALUE(10),
        .MAX_PACKETS(MAXP0), .CNT_WIDTH(16)
    ) dut0 (
        .aclk(clk), .rst(rst),
        .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(rdy0),
        .s_axis_tlast(tlast[0]), .enable(en[0]), .clear(clr[0]),
        .done(done0), .pkt_count(pkt0), .beat_count(beat0), .err_count(err0),
        .err_data(ed0), .err_last(el0), .last_data(ld0)
    );

    axis_sequence_checker #(
        .AXIS_TDATA_WIDTH(32), .VALUE_COUNT(VC), .START_VALUE(10),
        .MAX_PACKETS(MAXP1), .CNT_WIDTH(12)
    ) dut1 (
        .aclk(clk), .rst(rst),
        .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(rdy1),
        .s_axis_tlast(tlast[1]), .enable(en[1]), .clear(clr[1]),
        .done(done1), .pkt_count(pkt1), .beat_count(beat1), .err_count(err1),
        .err_data(ed1), .err_last(el1), .last_data(ld1)
    );

    // Reference model: packet-level bookkeeping from the behavioural rules.
    int          maxp[2] = '{MAXP0, MAXP1};
    int          cmax[2] = '{65535, 4095};
    bit          m_run [2];
    bit          m_done[2];
    bit          m_ed  [2];
    bit          m_el  [2];
    logic [31:0] m_exp [2];
    logic [31:0] m_last[2];
    int          m_idx [2];
    int          m_pkt [2];
    int          m_beat[2];
    int          m_err [2];
    bit          acc_w [2];
    int          toggles  = 0;
    logic        prev_rdy = 1'b0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_zero(input int d);
        m_run[d]  = 1'b0;
        m_done[d] = 1'b0;
        m_ed[d]   = 1'b0;
        m_el[d]   = 1'b0;
        m_exp[d]  = SV;
        m_last[d] = '0;
        m_idx[d]  = 0;
        m_pkt[d]  = 0;
        m_beat[d] = 0;
        m_err[d]  = 0;
    endtask

    task automatic model_step(input int d);
        bit dbad, atend, lbad, finished;
        finished = 1'b0;
        if (clr[d]) begin
            model_zero(d);
        end else begin
            if (acc_w[d]) begin
                dbad  = (tdata[d] != m_exp[d]);
                atend = (m_idx[d] == VC - 1);
                lbad  = (tlast[d] != atend);
                m_beat[d] = sat(m_beat[d] + 1, cmax[d]);
                if (dbad || lbad) m_err[d] = sat(m_err[d] + 1, cmax[d]);
                m_ed[d]   = m_ed[d] | dbad;
                m_el[d]   = m_el[d] | lbad;
                m_last[d] = tdata[d];
                if (tlast[d] || atend) begin
                    m_idx[d] = 0;
                    m_exp[d] = SV;
                end else begin
                    m_idx[d] = m_idx[d] + 1;
                    m_exp[d] = (dbad ? tdata[d] : m_exp[d]) + 32'd1;
                end
                if (tlast[d]) begin
                    m_pkt[d] = sat(m_pkt[d] + 1, cmax[d]);
                    finished = (maxp[d] != 0) && (m_pkt[d] == maxp[d]);
                end
            end
            if (!m_done[d]) begin
                if (finished) begin
                    m_done[d] = 1'b1;
                    m_run[d]  = 1'b0;
                end else begin
                    m_run[d] = en[d];
                end
            end
        end
    endtask

    task automatic check_outputs(input int d);
        chk("done",       d, done[d],  m_done[d]);
        chk("pkt_count",  d, pkt[d],   m_pkt[d]);
        chk("beat_count", d, beat[d],  m_beat[d]);
        chk("err_count",  d, errc[d],  m_err[d]);
        chk("err_data",   d, ed[d],    m_ed[d]);
        chk("err_last",   d, el[d],    m_el[d]);
        chk("last_data",  d, lastd[d], m_last[d]);
    endtask

    // One clock: ready checked mid-cycle with inputs stable, state after the edge.
    task automatic cycle();
        bit allowed;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            allowed = m_run[d] && en[d] && !clr[d];
`ifdef BACKPRESSURE_EN
            if (!allowed) chk("tready_gated", d, tready[d], 1'b0);
            acc_w[d] = tvalid[d] && allowed && (tready[d] === 1'b1);
`else
            chk("tready", d, tready[d], allowed);
            acc_w[d] = tvalid[d] && allowed;
`endif
        end
        if (tready[1] !== prev_rdy) toggles++;
        prev_rdy = tready[1];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            model_step(d);
            check_outputs(d);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            model_zero(d);
            check_outputs(d);
            chk("reset_tready", d, tready[d], 1'b0);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic send_run(input int d, input logic [31:0] start, input int n,
                            input bit with_last, input bit rnd);
        int waited;
        for (int i = 0; i < n; i++) begin
            tdata[d] = start + 32'(i);
            tlast[d] = with_last && (i == n - 1);
            waited   = 0;
            do begin
                if (rnd) begin
                    tvalid[d] = ($urandom_range(3) != 0);
                    en[d]     = ($urandom_range(31) != 0);
                end else begin
                    tvalid[d] = 1'b1;
                end
                cycle();
                waited++;
            end while (!acc_w[d] && waited < 500);
            if (!acc_w[d]) begin
                checks++;
                errors++;
                $error("FAIL handshake_timeout dut%0d observed=no_accept expected=accept tdata=%0d", d, tdata[d]);
            end
        end
    endtask

    task automatic clear_dut(input int d);
        tvalid[d] = 1'b0;
        clr[d]    = 1'b1;
        cycle();
        clr[d]    = 1'b0;
        chk("clear_pkt",  d, pkt[d],  0);
        chk("clear_beat", d, beat[d], 0);
        chk("clear_err",  d, errc[d], 0);
        chk("clear_done", d, done[d], 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            tdata[d] = '0; tvalid[d] = 1'b0; tlast[d] = 1'b0;
            en[d] = 1'b0; clr[d] = 1'b0; acc_w[d] = 1'b0;
        end
        do_reset();

        // Clean packet 10..17 stops dut0 in DONE.
        en[0] = 1'b1;
        send_run(0, 32'd10, 8, 1'b1, 1'b0);
        cycle();
        chk("t1_pkt",   0, pkt[0],   1);
        chk("t1_beat",  0, beat[0],  8);
        chk("t1_err",   0, errc[0],  0);
        chk("t1_flags", 0, {ed[0], el[0]}, 2'b00);
        chk("t1_done",  0, done[0],  1);
        chk("t1_ready", 0, tready[0], 0);
        chk("t1_last",  0, lastd[0], 17);
        clear_dut(0);

        // Discontinuity 12 -> 20 counts once and resynchronises.
        send_run(0, 32'd10, 3, 1'b0, 1'b0);
        send_run(0, 32'd20, 5, 1'b1, 1'b0);
        chk("t2_err_data", 0, ed[0],   1);
        chk("t2_err_last", 0, el[0],   0);
        chk("t2_err",      0, errc[0], 1);
        chk("t2_pkt",      0, pkt[0],  1);
        clear_dut(0);

        // Enable drop mid-packet with tvalid held; packet resumes.
        send_run(0, 32'd10, 4, 1'b0, 1'b0);
        en[0] = 1'b0; tdata[0] = 32'd14; tvalid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t4_stall_ready", 0, tready[0], 0);
        end
        en[0] = 1'b1;
        send_run(0, 32'd14, 4, 1'b1, 1'b0);
        chk("t4_err", 0, errc[0], 0);
        chk("t4_pkt", 0, pkt[0],  1);
        clear_dut(0);

        // Reset mid-packet, then a full packet, clear, and a fresh packet.
        send_run(0, 32'd10, 3, 1'b0, 1'b0);
        do_reset();
        chk("t5_rst_beat", 0, beat[0], 0);
        send_run(0, 32'd10, 8, 1'b1, 1'b0);
        chk("t5_err",  0, errc[0], 0);
        chk("t5_done", 0, done[0], 1);
        clear_dut(0);
        send_run(0, 32'd10, 8, 1'b1, 1'b0);
        chk("t5_fresh_err", 0, errc[0], 0);
        chk("t5_fresh_pkt", 0, pkt[0],  1);
        tvalid[0] = 1'b0; en[0] = 1'b0;

        // Early tlast on the fifth beat, then a good packet.
        en[1] = 1'b1;
        send_run(1, 32'd10, 5, 1'b1, 1'b0);
        send_run(1, 32'd10, 8, 1'b1, 1'b0);
        chk("t3_err_last", 1, el[1],   1);
        chk("t3_err_data", 1, ed[1],   0);
        chk("t3_err",      1, errc[1], 1);
        chk("t3_pkt",      1, pkt[1],  2);
        chk("t3_done",     1, done[1], 0);
        clear_dut(1);

        // Missing tlast: index wraps, no packet credited.
        send_run(1, 32'd10, 8, 1'b0, 1'b0);
        send_run(1, 32'd10, 8, 1'b1, 1'b0);
        chk("t3b_err_last", 1, el[1],   1);
        chk("t3b_err",      1, errc[1], 1);
        chk("t3b_pkt",      1, pkt[1],  1);
        chk("t3b_beat",     1, beat[1], 16);
        clear_dut(1);

        // 1000 packets with random valid gaps and enable drops.
        toggles = 0;
        for (int p = 0; p < 1000; p++) begin
            send_run(1, 32'd10, 8, 1'b1, 1'b1);
        end
        en[1] = 1'b1;
        tvalid[1] = 1'b0;
        cycle();
        chk("t6_err",     1, errc[1], 0);
        chk("t6_pkt",     1, pkt[1],  1000);
        chk("t6_beat_sat",1, beat[1], 4095);
        chk("t6_flags",   1, {ed[1], el[1]}, 2'b00);
        chk("t6_last",    1, lastd[1], 17);
        chk("t6_toggles", 1, (toggles > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
